// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings and phase state type for the timed traffic controller
package traffic_pkg;
  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;
  localparam logic [1:0] LIGHT_DARK   = 2'b11;
  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_RED    = 2'b10,
    ST_FLASH  = 2'b11
  } state_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase tick counter with clear, hold-at-zero and enable, plus end-of-phase compare
module phase_timer
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int RED_TICKS    = 6,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic             en,
  input  state_t           sel,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RED_TICKS - 1);
  logic [CNT_W-1:0] cnt_d, cnt_q, lim;
  always_comb begin
    lim   = sel == ST_GREEN ? G_LAST : sel == ST_YELLOW ? Y_LAST : R_LAST;
    cnt_d = (clr || hold) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt  = cnt_q;
  assign last = cnt_q == lim;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: tick-timed Green/Yellow/Red sequencer with pedestrian hold and flashing maintenance mode
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS     = 8,
  parameter int YELLOW_TICKS    = 3,
  parameter int RED_TICKS       = 6,
  parameter int MIN_GREEN_TICKS = 2,
  parameter int CNT_W           = 8
) (
  input  logic             clk_main,
  input  logic             rst_main,
  input  logic             tick_en,
  input  logic             hold_red,
  input  logic             flash_mode,
  output logic [1:0]       traffic_light,
  output logic             ped_walk,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_start
);
  localparam int MAX_T = GREEN_TICKS > YELLOW_TICKS
                       ? (GREEN_TICKS > RED_TICKS ? GREEN_TICKS : RED_TICKS)
                       : (YELLOW_TICKS > RED_TICKS ? YELLOW_TICKS : RED_TICKS);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN_TICKS - 1);
  if (longint'(MAX_T - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_err
    $error("CNT_W too narrow for the longest phase");
  end
  if (MIN_GREEN_TICKS < 1 || MIN_GREEN_TICKS > GREEN_TICKS) begin : g_min_err
    $error("MIN_GREEN_TICKS out of range");
  end
  state_t     state_q, state_d;
  logic       flash_q, flash_d, walk_q, walk_d, ps_q, ps_d, clr, hold, last;
  logic [1:0] light_q, light_d;
  phase_timer #(
    .GREEN_TICKS (GREEN_TICKS),
    .YELLOW_TICKS(YELLOW_TICKS),
    .RED_TICKS   (RED_TICKS),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk (clk_main),
    .rst (rst_main),
    .clr (clr),
    .hold(hold),
    .en  (tick_en),
    .sel (state_q),
    .cnt (phase_cnt),
    .last(last)
  );
  // flash request outranks the pedestrian hold, which outranks normal expiry
  always_comb begin
    state_d = state_q;
    flash_d = flash_q;
    clr     = 1'b0;
    hold    = 1'b0;
    if (tick_en && flash_mode) begin
      state_d = ST_FLASH;
      clr     = state_q != ST_FLASH;
      flash_d = state_q == ST_FLASH ? !flash_q : 1'b0;
    end else if (state_q == ST_FLASH) begin
      clr     = tick_en;
      state_d = tick_en ? ST_RED : ST_FLASH;
      flash_d = tick_en ? 1'b0 : flash_q;
    end else if (state_q == ST_GREEN) begin
      clr     = tick_en && (last || (hold_red && phase_cnt >= MIN_LAST));
      state_d = clr ? ST_YELLOW : ST_GREEN;
    end else if (state_q == ST_YELLOW) begin
      clr     = tick_en && last;
      state_d = clr ? ST_RED : ST_YELLOW;
    end else begin
      hold    = hold_red;
      clr     = tick_en && last && !hold_red;
      state_d = clr ? ST_GREEN : ST_RED;
    end
    light_d = state_d == ST_GREEN  ? LIGHT_GREEN
            : state_d == ST_YELLOW ? LIGHT_YELLOW
            : state_d == ST_RED    ? LIGHT_RED
            : flash_d              ? LIGHT_DARK : LIGHT_YELLOW;
    walk_d  = state_d == ST_RED && state_q == ST_RED && hold_red;
    ps_d    = state_d != state_q;
  end
  always_ff @(posedge clk_main) begin
    if (rst_main) begin
      state_q <= ST_GREEN;
      flash_q <= 1'b0;
      light_q <= LIGHT_GREEN;
      walk_q  <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flash_q <= flash_d;
      light_q <= light_d;
      walk_q  <= walk_d;
      ps_q    <= ps_d;
    end
  end
  assign traffic_light = light_q;
  assign ped_walk      = walk_q;
  assign phase_start   = ps_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed vectors push expected outputs to a scoreboard; a negedge monitor pops and compares
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;
  localparam logic [1:0] G = LIGHT_GREEN, Y = LIGHT_YELLOW, R = LIGHT_RED, D = LIGHT_DARK;
  typedef struct {
    int         tid;
    int         step;
    logic [1:0] l;
    logic       w;
    logic [7:0] c;
    logic       p;
  } exp_t;
  logic       clk_main = 1'b0;
  logic       rst_main = 1'b1, tick_en = 1'b0, hold_red = 1'b0, flash_mode = 1'b0;
  logic [1:0] traffic_light;
  logic       ped_walk, phase_start;
  logic [7:0] phase_cnt;
  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0, tid = 0, step = 0;
  traffic_phase_ctrl dut (
    .clk_main     (clk_main),
    .rst_main     (rst_main),
    .tick_en      (tick_en),
    .hold_red     (hold_red),
    .flash_mode   (flash_mode),
    .traffic_light(traffic_light),
    .ped_walk     (ped_walk),
    .phase_cnt    (phase_cnt),
    .phase_start  (phase_start)
  );
  always #5 clk_main = ~clk_main;
  always @(negedge clk_main) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if ({traffic_light, ped_walk, phase_cnt, phase_start} !== {e.l, e.w, e.c, e.p}) begin
        n_fail++;
        $display("FAIL t%0d.%0d light/walk/cnt/start got %b/%b/%0d/%b want %b/%b/%0d/%b",
                 e.tid, e.step, traffic_light, ped_walk, phase_cnt, phase_start, e.l, e.w, e.c, e.p);
      end
    end
  end
  task automatic cyc(input bit r, t, h, f, input logic [1:0] l, input bit w, input int c, input bit p);
    @(negedge clk_main);
    #1;
    rst_main = r; tick_en = t; hold_red = h; flash_mode = f;
    sb.push_back('{tid, step, l, w, 8'(c), p});
    step++;
  endtask
  task automatic run(input bit h, input logic [1:0] l, input int c0, input int c1, input bit p);
    for (int c = c0; c <= c1; c++) cyc(0, 1, h, 0, l, 0, c, p && c == c0);
  endtask
  task automatic start(input int id);
    tid = id; step = 0;
    cyc(1, 1, 1, 0, G, 0, 0, 0);
  endtask
  initial begin
    start(1);
    run(0, G, 1, 7, 0); run(0, Y, 0, 2, 1); run(0, R, 0, 5, 1);
    run(0, G, 0, 7, 1); run(0, Y, 0, 2, 1); run(0, R, 0, 0, 1);
    start(2);
    cyc(0, 1, 1, 0, G, 0, 1, 0);
    run(1, Y, 0, 2, 1);
    cyc(0, 1, 1, 0, R, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, R, 1, 0, 0);
    run(0, R, 1, 5, 0); run(0, G, 0, 1, 1);
    start(3);
    for (int i = 1; i <= 68; i++)
      cyc(0, i % 4 == 0, 0, 0,
          i < 32 ? G : i < 44 ? Y : i < 68 ? R : G, 0,
          i < 32 ? i / 4 : i < 44 ? (i - 32) / 4 : i < 68 ? (i - 44) / 4 : 0,
          i == 32 || i == 44 || i == 68);
    start(4);
    run(0, G, 1, 7, 0);
    cyc(0, 1, 0, 0, Y, 0, 0, 1);
    cyc(0, 1, 0, 1, Y, 0, 0, 1);
    cyc(0, 1, 0, 1, D, 0, 1, 0);
    cyc(0, 0, 0, 0, D, 0, 1, 0);
    cyc(0, 1, 0, 1, Y, 0, 2, 0);
    cyc(0, 1, 1, 1, D, 0, 3, 0);
    cyc(0, 1, 0, 0, R, 0, 0, 1);
    run(0, R, 1, 5, 0); run(0, G, 0, 0, 1);
    start(5);
    cyc(0, 1, 1, 0, G, 0, 1, 0);
    run(1, Y, 0, 2, 1);
    cyc(0, 1, 1, 0, R, 0, 0, 1);
    cyc(0, 1, 1, 0, R, 1, 0, 0);
    cyc(1, 1, 1, 0, G, 0, 0, 0);
    cyc(0, 1, 0, 0, G, 0, 1, 0);
    start(6);
    cyc(0, 1, 1, 1, Y, 0, 0, 1);
    cyc(0, 1, 1, 1, D, 0, 1, 0);
    cyc(0, 1, 0, 0, R, 0, 0, 1);
    run(0, R, 1, 5, 0); run(0, G, 0, 0, 1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_main);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
